asm_stream_encoder: RTL
=======================

// Module: asm_stream_encoder
// PURPOSE
//   Sequential successor to the single-word assemble encoder. Accepts decoded MIPS instruction fields over valid/ready,
//   encodes each into a 32-bit machine word, tags it with its word address, and buffers the pair in a DEPTH-entry FIFO.
//   Sits between the bench/loader front end and instruction-memory initialisation logic.
// PARAMETERS
//   DEPTH    4             FIFO entries; power of two, >=2
//   AW       $clog2(DEPTH) pointer width; derived, do not override
//   PC_BASE  32'h0000_3000 address assigned to the first word after reset
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high; clears FIFO, PC and err
//   in_valid   in   1   field bundle valid
//   in_ready   out  1   = !full; no bypass (a full FIFO does not accept even if out_ready=1)
//   in_op      in   4   0 ADD, 1 SUB, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 LUI, 7 JAL, 8 JR, 9 NOP, 10-15 illegal
//   in_rs      in   5   rs field
//   in_rt      in   5   rt field
//   in_rd      in   5   rd field
//   in_imm     in   26  I-types use [15:0]; JAL uses [25:0]
//   out_valid  out  1   = !empty
//   out_ready  in   1   consumer pop request
//   out_word   out  32  head encoded word
//   out_addr   out  32  head word address
//   count      out  AW+1 occupancy, 0..DEPTH
//   err        out  1   sticky illegal-op flag
// BEHAVIOUR
//   - Reset values: in_ready=1, out_valid=0, out_word=0, out_addr=0, count=0, err=0; PC=PC_BASE.
//   - Push when in_valid&&in_ready; pop when out_valid&&out_ready; both evaluated on the same edge.
//   - Latency: a word accepted at edge N is visible on out_* after edge N (earliest pop at edge N+1).
//   - Encoding: R-type {6'h00, rs, rt, rd, 5'd0, funct}. ADD funct 6'h20, SUB 6'h22, JR {6'h00, rs, 15'd0, 6'h08}.
//   - I-type {opc, rs, rt, imm[15:0]}: ORI 6'h0d, LW 6'h23, SW 6'h2b, BEQ 6'h04, LUI 6'h0f (rs forced to 0).
//   - JAL {6'h03, imm[25:0]}. NOP 32'h0000_0000.
//   - out_addr is the PC at accept time. PC += 4 per pushed word; wraps modulo 2^32.
//   - Pointers wrap modulo DEPTH. Simultaneous push+pop when 0<count<DEPTH: count unchanged, both pointers advance.
//   - Push at count=DEPTH is impossible (in_ready=0). Pop at count=0 is ignored.
//   - out_word/out_addr are don't-care when out_valid=0; the bench checks them only when valid.
//   - Reset mid-stream: all buffered words are dropped and the next accepted word gets PC_BASE.
// CONFIGURATION
//   ASM_CHECK_EN defined:
//     - An illegal op (10-15) is accepted (handshake completes) but not pushed.
//     - PC does not advance; err is set the next cycle and holds until reset.
//   ASM_CHECK_EN undefined:
//     - An illegal op is pushed as 32'h0000_0000 and PC advances by 4.
//     - err is constant 0.
// TESTING
//   1. reset; push ORI rs=0 rt=1 imm=16'h1234 -> next cycle out_valid=1, out_word=32'h3401_1234, out_addr=32'h0000_3000.
//   2. push ADD rd=3 rs=1 rt=2, LUI rt=2 imm=16'hABCD, BEQ rs=1 rt=2 imm=16'hFFFF, JAL imm=26'h000_0C00 (out_ready=0)
//      -> pops return 32'h0022_1820 @3000, 32'h3C02_ABCD @3004, 32'h1022_FFFF @3008, 32'h0C00_0C00 @300C.
//   3. DEPTH=4 with out_ready=0: push 4 words -> count=4, in_ready=0, 5th word held.
//      Then one pop -> 5th accepted at the next edge, count stays 4.
//   4. count=2, push+pop on the same edge -> count=2, FIFO order preserved.
//      Continue through 3 pointer wraps without loss.
//   5. in_op=4'hF: with ASM_CHECK_EN -> count unchanged, err=1 sticky, next word address unchanged;
//      without it -> word 32'h0 pushed, err=0.
//   6. reset asserted with 3 words buffered -> next cycle count=0, out_valid=0; next push gets out_addr=32'h0000_3000.

Source files
------------

// File: rtl/asm_stream_if.sv
// Valid/ready field-bundle and encoded-word stream bundle for asm_stream_encoder.
// The master drives the field bundle and pop requests; the slave is the encoder.
interface asm_stream_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [AW:0] count;
  logic        err;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_addr, count, err
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_addr, count, err
  );
endinterface

// File: rtl/asm_stream_encoder.sv
// Encodes MIPS field bundles into 32-bit words tagged with their address, buffered in a DEPTH-entry FIFO.
// Optional ASM_CHECK_EN: drop illegal ops (10-15) and raise a sticky err flag instead of pushing zero.
module asm_stream_encoder #(
  parameter int          DEPTH   = 4,
  parameter int          AW      = $clog2(DEPTH),
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,
  asm_stream_if.slave  s
);

  logic [31:0] mem_word_r [DEPTH];
  logic [31:0] mem_addr_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [31:0]   pc_r;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   enc_word_s;

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [25:0] imm
  );
    logic [31:0] w;
    case (op)
      4'd0:    w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:    w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:    w = {6'h0d, rs, rt, imm[15:0]};
      4'd3:    w = {6'h23, rs, rt, imm[15:0]};
      4'd4:    w = {6'h2b, rs, rt, imm[15:0]};
      4'd5:    w = {6'h04, rs, rt, imm[15:0]};
      4'd6:    w = {6'h0f, 5'd0, rt, imm[15:0]};
      4'd7:    w = {6'h03, imm};
      4'd8:    w = {6'h00, rs, 15'd0, 6'h08};
      default: w = 32'h0000_0000;  // NOP and illegal ops
    endcase
    return w;
  endfunction

  assign enc_word_s = encode(s.in_op, s.in_rs, s.in_rt, s.in_rd, s.in_imm);
  assign accept_s   = s.in_valid && s.in_ready;
  assign pop_s      = s.out_valid && s.out_ready;

`ifdef ASM_CHECK_EN
  logic illegal_s;
  logic err_r;

  assign illegal_s = (s.in_op > 4'd9);
  assign push_s    = accept_s && !illegal_s;
  assign s.err     = err_r;

  // Sticky flag for an accepted-but-dropped illegal op.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (accept_s && illegal_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign push_s = accept_s;
  assign s.err  = 1'b0;
`endif

  // FIFO storage, pointers, occupancy and running word address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_word_r[i] <= 32'h0000_0000;
        mem_addr_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      pc_r     <= PC_BASE;
    end else begin
      if (push_s) begin
        mem_word_r[wr_ptr_r] <= enc_word_s;
        mem_addr_r[wr_ptr_r] <= pc_r;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
        pc_r                 <= pc_r + 32'd4;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign s.in_ready  = (count_r != (AW+1)'(DEPTH));
  assign s.out_valid = (count_r != '0);
  assign s.out_word  = mem_word_r[rd_ptr_r];
  assign s.out_addr  = mem_addr_r[rd_ptr_r];
  assign s.count     = count_r;

endmodule
